// File: rtl/sap1_fetch_unit_if.sv
// sap1_fetch_unit_if: memory bus and execute-stage handshake of the SAP-1 fetch unit
interface sap1_fetch_unit_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ram_address;
  logic              ram_oe_n;
  logic [DATA_W-1:0] bus_in;
  logic [3:0]        ir_opcode;
  logic [3:0]        ir_operand;
  logic [DATA_W-1:0] operand_data;
  logic              instr_valid;
  logic              instr_ready;
  modport master (
    output ram_address, ram_oe_n, ir_opcode, ir_operand, operand_data, instr_valid,
    input  bus_in, instr_ready
  );
  modport slave (
    input  ram_address, ram_oe_n, ir_opcode, ir_operand, operand_data, instr_valid,
    output bus_in, instr_ready
  );
endinterface

// File: rtl/sap1_fetch_unit.sv
// sap1_fetch_unit: SAP-1 instruction/operand fetch with valid/ready hand-off to execute
module sap1_fetch_unit #(
  parameter int              ADDR_W     = 4,
  parameter int              DATA_W     = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter logic [3:0]      HLT_OPCODE = 4'b1111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  sap1_fetch_unit_if.master  bus,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH_A = 3'd1;
  localparam logic [2:0] FETCH_D = 3'd2;
  localparam logic [2:0] OPER_A  = 3'd3;
  localparam logic [2:0] OPER_D  = 3'd4;
  localparam logic [2:0] PRESENT = 3'd5;
  localparam logic [2:0] HALT    = 3'd6;
  logic [2:0] state;
  logic [3:0] op;
  assign op = bus.bus_in[DATA_W-1 -: 4];
  // Sequencer: address is loaded on entry to an address phase, OE pulses low for exactly the
  // following data phase, and instr_valid rises one cycle after capture so the execute stage
  // always sees settled instruction and operand values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      pc               <= PC_RESET;
      halted           <= 1'b0;
      bus.ram_address  <= '0;
      bus.ram_oe_n     <= 1'b1;
      bus.ir_opcode    <= '0;
      bus.ir_operand   <= '0;
      bus.operand_data <= '0;
      bus.instr_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state           <= FETCH_A;
          bus.ram_address <= pc;
        end
        FETCH_A: begin
          state        <= FETCH_D;
          bus.ram_oe_n <= 1'b0;
        end
        FETCH_D: begin
          bus.ram_oe_n   <= 1'b1;
          bus.ir_opcode  <= op;
          bus.ir_operand <= bus.bus_in[3:0];
          pc             <= pc + ADDR_W'(1);
          if (op == HLT_OPCODE) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (op < 4'd3) begin
            state           <= OPER_A;
            bus.ram_address <= ADDR_W'(bus.bus_in[3:0]);
          end else begin
            state            <= PRESENT;
            bus.operand_data <= '0;
          end
        end
        OPER_A: begin
          state        <= OPER_D;
          bus.ram_oe_n <= 1'b0;
        end
        OPER_D: begin
          state            <= PRESENT;
          bus.ram_oe_n     <= 1'b1;
          bus.operand_data <= bus.bus_in;
        end
        PRESENT: if (!bus.instr_valid) bus.instr_valid <= 1'b1;
          else if (bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            state           <= FETCH_A;
            bus.ram_address <= pc;
          end
        HALT: bus.ram_oe_n <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sap1_fetch_unit.sv
// tb_sap1_fetch_unit: directed vector bench for the SAP-1 fetch unit
module tb_sap1_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, ready0 = 1'b0;
  logic [3:0] pc0, pc1;
  logic halted0, halted1;
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  int total = 0, passed = 0;
  int reads0 = 0, reads1 = 0, b2b = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;
  logic [3:0] addr_log0 [256];

  always #5 clk = ~clk;

  sap1_fetch_unit_if #(.ADDR_W(4), .DATA_W(8)) b0 ();
  sap1_fetch_unit_if #(.ADDR_W(4), .DATA_W(8)) b1 ();

  assign b0.bus_in = b0.ram_oe_n ? 8'hAA : mem0[b0.ram_address];
  assign b1.bus_in = b1.ram_oe_n ? 8'hAA : mem1[b1.ram_address];
  assign b0.instr_ready = ready0;
  assign b1.instr_ready = 1'b1;

  sap1_fetch_unit u0 (.clk(clk), .rst_n(rst_n), .start(start0), .bus(b0.master), .pc(pc0), .halted(halted0));
  sap1_fetch_unit #(.PC_RESET(4'd14)) u1 (.clk(clk), .rst_n(rst_n), .start(start1), .bus(b1.master), .pc(pc1), .halted(halted1));

  always @(negedge clk) begin
    if (!b0.ram_oe_n) begin
      addr_log0[reads0 & 255] = b0.ram_address;
      reads0++;
    end
    if (!b1.ram_oe_n) reads1++;
    if ((!b0.ram_oe_n && prev0) || (!b1.ram_oe_n && prev1)) b2b++;
    prev0 = !b0.ram_oe_n;
    prev1 = !b1.ram_oe_n;
  end

  typedef struct {
    logic [7:0] instr;
    logic [7:0] oper;
    logic [7:0] exp_data;
    int         exp_lat;
    int         exp_reads;
  } vec_t;
  vec_t tv [6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic wait_valid0(output int k);
    k = 0;
    while (!b0.instr_valid && k < 20) begin
      tick();
      k++;
    end
  endtask

  initial begin
    int k, r0, r1, errs, n;
    logic [21:0] snap;
    logic [7:0] seen_ir [2];
    logic [3:0] seen_pc [2];
    tv[0] = '{8'hE0, 8'h77, 8'h00, 3, 1};
    tv[1] = '{8'h09, 8'h3C, 8'h3C, 5, 2};
    tv[2] = '{8'h15, 8'h7F, 8'h7F, 5, 2};
    tv[3] = '{8'h20, 8'h20, 8'h20, 5, 2};
    tv[4] = '{8'h3A, 8'h99, 8'h00, 3, 1};
    tv[5] = '{8'h2F, 8'hC3, 8'hC3, 5, 2};
    for (int i = 0; i < 16; i++) begin mem0[i] = 8'h55; mem1[i] = 8'h55; end

    do_reset();
    chk("rst_addr", int'(b0.ram_address), 0);
    chk("rst_oe_n", int'(b0.ram_oe_n), 1);
    chk("rst_opcode", int'(b0.ir_opcode), 0);
    chk("rst_operand", int'(b0.ir_operand), 0);
    chk("rst_data", int'(b0.operand_data), 0);
    chk("rst_valid", int'(b0.instr_valid), 0);
    chk("rst_pc", int'(pc0), 0);
    chk("rst_halted", int'(halted0), 0);
    chk("rst_pc_param", int'(pc1), 14);
    errs = 0;
    r0 = reads0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b0.ram_oe_n !== 1'b1 || b0.instr_valid !== 1'b0 || pc0 !== 4'd0 || halted0 !== 1'b0) errs++;
    end
    chk("idle_stable", errs, 0);
    chk("idle_no_reads", reads0 - r0, 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int j = 0; j < 16; j++) mem0[j] = 8'h55;
      mem0[tv[i].instr[3:0]] = tv[i].oper;
      mem0[0] = tv[i].instr;
      r0 = reads0;
      pulse0();
      wait_valid0(k);
      chk($sformatf("v%0d_latency", i), k, tv[i].exp_lat);
      chk($sformatf("v%0d_opcode", i), int'(b0.ir_opcode), int'(tv[i].instr[7:4]));
      chk($sformatf("v%0d_operand", i), int'(b0.ir_operand), int'(tv[i].instr[3:0]));
      chk($sformatf("v%0d_data", i), int'(b0.operand_data), int'(tv[i].exp_data));
      chk($sformatf("v%0d_pc", i), int'(pc0), 1);
      chk($sformatf("v%0d_reads", i), reads0 - r0, tv[i].exp_reads);
      chk($sformatf("v%0d_fetch_addr", i), int'(addr_log0[r0]), 0);
      if (tv[i].exp_reads == 2)
        chk($sformatf("v%0d_oper_addr", i), int'(addr_log0[r0 + 1]), int'(tv[i].instr[3:0]));
    end

    do_reset();
    for (int j = 0; j < 16; j++) mem0[j] = 8'h55;
    mem0[0] = 8'h09; mem0[9] = 8'h3C; mem0[1] = 8'hE5;
    pulse0();
    wait_valid0(k);
    chk("bp_first_lat", k, 5);
    snap = {b0.ir_opcode, b0.ir_operand, b0.operand_data, pc0, b0.instr_valid, b0.ram_oe_n};
    r0 = reads0;
    errs = 0;
    repeat (7) begin
      tick();
      if ({b0.ir_opcode, b0.ir_operand, b0.operand_data, pc0, b0.instr_valid, b0.ram_oe_n} !== snap) errs++;
    end
    chk("bp_stable", errs, 0);
    chk("bp_no_reads", reads0 - r0, 0);
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;
    chk("bp_valid_drop", int'(b0.instr_valid), 0);
    wait_valid0(k);
    chk("bp_next_lat", k, 3);
    chk("bp_next_addr", int'(addr_log0[r0]), 1);
    chk("bp_next_ir", int'({b0.ir_opcode, b0.ir_operand}), 8'hE5);
    chk("bp_next_data", int'(b0.operand_data), 0);
    chk("bp_next_pc", int'(pc0), 2);

    do_reset();
    mem1[14] = 8'hE1; mem1[15] = 8'hE2; mem1[0] = 8'hF0;
    r1 = reads1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    k = 0; n = 0;
    while (!halted1 && k < 40) begin
      tick();
      k++;
      if (b1.instr_valid) begin
        if (n < 2) begin
          seen_ir[n] = {b1.ir_opcode, b1.ir_operand};
          seen_pc[n] = pc1;
        end
        n++;
      end
    end
    chk("wrap_halt_lat", k, 10);
    chk("wrap_presented", n, 2);
    chk("wrap_ir0", int'(seen_ir[0]), 8'hE1);
    chk("wrap_pc0", int'(seen_pc[0]), 15);
    chk("wrap_ir1", int'(seen_ir[1]), 8'hE2);
    chk("wrap_pc1", int'(seen_pc[1]), 0);
    chk("halt_pc", int'(pc1), 1);
    chk("halt_reads", reads1 - r1, 3);
    r1 = reads1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      start1 = i[0];
      tick();
      if (b1.ram_oe_n !== 1'b1 || halted1 !== 1'b1 || b1.instr_valid !== 1'b0 || pc1 !== 4'd1) errs++;
    end
    start1 = 1'b0;
    chk("halt_sticky", errs, 0);
    chk("halt_no_reads", reads1 - r1, 0);

    do_reset();
    for (int j = 0; j < 16; j++) mem0[j] = 8'h55;
    mem0[0] = 8'h09; mem0[9] = 8'h3C;
    pulse0();
    repeat (3) tick();
    chk("mid_in_oper_d", int'(b0.ram_oe_n), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_oe_release", int'(b0.ram_oe_n), 1);
    chk("mid_pc", int'(pc0), 0);
    chk("mid_ir", int'({b0.ir_opcode, b0.ir_operand}), 0);
    chk("mid_data", int'(b0.operand_data), 0);
    chk("mid_addr", int'(b0.ram_address), 0);
    chk("mid_valid", int'(b0.instr_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    r0 = reads0;
    pulse0();
    wait_valid0(k);
    chk("mid_restart_lat", k, 5);
    chk("mid_restart_addr", int'(addr_log0[r0]), 0);
    chk("mid_restart_data", int'(b0.operand_data), 8'h3C);
    chk("mid_restart_pc", int'(pc0), 1);

    chk("no_back_to_back_oe", b2b, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
